// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcodes, funct3 codes, FSM state type and the
// single-cycle ALU result function shared by rv32i_alu_exec.
package rv32i_pkg;

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [31:0] alu_calc(
    input logic [2:0]  f3,
    input logic        sub,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] sh
  );
    logic [31:0] r;
    r = '0;
    unique case (f3)
      F3_ADD:        r = sub ? a - b : a + b;
      F3_SLL, F3_SR: r = sh;
      F3_SLT:        r = {31'd0, $signed(a) < $signed(b)};
      F3_SLTU:       r = {31'd0, a < b};
      F3_XOR:        r = a ^ b;
      F3_OR:         r = a | b;
      F3_AND:        r = a & b;
      default:       r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32i_shifter.sv
// rv32i_shifter: barrel (RV_ALU_BARREL_EN) or iterative shifter.
// Ports: clk, resetn, load_i/val_i/shamt_i/left_i/arith_i in;
// imm_res_o (same-cycle result), step_res_o (next iterative
// value), last_o (final iterative step this cycle) out.
module rv32i_shifter #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic [31:0] val_i,
  input  logic [4:0]  shamt_i,
  input  logic        left_i,
  input  logic        arith_i,
  output logic [31:0] imm_res_o,
  output logic [31:0] step_res_o,
  output logic        last_o
);

`ifdef RV_ALU_BARREL_EN

  logic unused_ok;
  assign unused_ok = ^{clk, resetn, load_i};

  always_comb begin
    imm_res_o = val_i >> shamt_i;
    if (left_i)
      imm_res_o = val_i << shamt_i;
    else if (arith_i)
      imm_res_o = 32'($signed(val_i) >>> shamt_i);
  end

  assign step_res_o = '0;
  assign last_o     = 1'b0;

`else

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  logic [31:0] val_q, val_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, arith_q;
  logic        big, fill;

  // Full step while enough distance remains, then single bits.
  always_comb begin
    big   = cnt_q >= STEP;
    fill  = arith_q & val_q[31];
    cnt_d = cnt_q - (big ? STEP : 5'd1);
    if (left_q)
      val_d = big ? {val_q[31-SHIFT_STEP:0], {SHIFT_STEP{1'b0}}}
                  : {val_q[30:0], 1'b0};
    else
      val_d = big ? {{SHIFT_STEP{fill}}, val_q[31:SHIFT_STEP]}
                  : {fill, val_q[31:1]};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      val_q   <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load_i) begin
      val_q   <= val_i;
      cnt_q   <= shamt_i;
      left_q  <= left_i;
      arith_q <= arith_i;
    end else if (cnt_q != 5'd0) begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  // Zero-distance shifts never load; they pass the operand through.
  assign imm_res_o  = val_i;
  assign step_res_o = val_d;
  assign last_o     = (cnt_q != 5'd0) && (cnt_d == 5'd0);

`endif

endmodule

// File: rtl/rv32i_alu_exec.sv
// rv32i_alu_exec: RV32I ALUreg/ALUimm execute unit, IDLE/SHIFT/DONE.
// In: clk, resetn, start, instr, rs1, rs2. Out: ready, done, wb_data,
// wb_en, wb_rd. Define RV_ALU_BARREL_EN for single-cycle shifts.
module rv32i_alu_exec
  import rv32i_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        ready,
  output logic        done,
  output logic [31:0] wb_data,
  output logic        wb_en,
  output logic [4:0]  wb_rd
);

  state_e      state_q, state_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        alu_q, alu_d;

  logic [2:0]  f3;
  logic        is_reg, is_imm, is_alu, sub;
  logic        use_iter, load;
  logic [31:0] op2, sh_imm, sh_step;
  logic        sh_last;
  logic        unused_ok;

  assign f3     = instr[14:12];
  assign is_reg = instr[6:0] == OP_ALUREG;
  assign is_imm = instr[6:0] == OP_ALUIMM;
  assign is_alu = is_reg | is_imm;
  assign sub    = is_reg & instr[30];
  assign op2    = is_reg ? rs2
                         : {{20{instr[31]}}, instr[31:20]};

  assign unused_ok = ^instr[19:15];

`ifdef RV_ALU_BARREL_EN
  assign use_iter = 1'b0;
`else
  logic is_shift;
  assign is_shift = is_alu & ((f3 == F3_SLL) | (f3 == F3_SR));
  assign use_iter = is_shift & (op2[4:0] != 5'd0);
`endif

  rv32i_shifter #(
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (load),
    .val_i      (rs1),
    .shamt_i    (op2[4:0]),
    .left_i     (f3 == F3_SLL),
    .arith_i    (instr[30]),
    .imm_res_o  (sh_imm),
    .step_res_o (sh_step),
    .last_o     (sh_last)
  );

  always_comb begin
    state_d   = state_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    alu_d     = alu_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          wb_rd_d = instr[11:7];
          alu_d   = is_alu;
          if (use_iter) begin
            load    = 1'b1;
            state_d = SHIFT;
          end else begin
            wb_data_d = is_alu
              ? alu_calc(f3, sub, rs1, op2, sh_imm)
              : 32'd0;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        if (sh_last) begin
          wb_data_d = sh_step;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      alu_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      alu_q     <= alu_d;
    end
  end

  assign ready   = state_q == IDLE;
  assign done    = state_q == DONE;
  assign wb_data = wb_data_q;
  assign wb_rd   = wb_rd_q;
  // x0 is never written, though the value is still presented.
  assign wb_en   = done & alu_q & (wb_rd_q != 5'd0);

endmodule

// File: doc/rv32i_alu_exec.md
RV32I_ALU_EXEC -- requirements
Module: rv32i_alu_exec

Interface
- REQ-001 SHALL have parameter SHIFT_STEP, default 4: bits shifted per iterative cycle; legal values 1 or 4.
- REQ-002 SHALL have port clk, input, 1: system clock; every register updates on its rising edge.
- REQ-003 SHALL have port resetn, input, 1: reset, synchronous and active-low.
- REQ-004 SHALL have port start, input, 1: request to execute; accepted only in a cycle where ready=1.
- REQ-005 SHALL have port instr, input, 32: instruction word, ALUreg (0110011) or ALUimm (0010011).
- REQ-006 SHALL have port rs1, input, 32: first source register value.
- REQ-007 SHALL have port rs2, input, 32: second source register value.
- REQ-008 SHALL have port ready, output, 1: high when idle and able to accept start.
- REQ-009 SHALL have port done, output, 1: one-cycle pulse marking a valid result.
- REQ-010 SHALL have port wb_data, output, 32: write-back value.
- REQ-011 SHALL have port wb_en, output, 1: register-bank write enable; high only while done=1.
- REQ-012 SHALL have port wb_rd, output, 5: destination register index, instr[11:7].

Function
- REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE; ready=1 only in IDLE; done=1 only in DONE.
- REQ-014 SHALL, on start accepted in IDLE, register instr, rs1 and the second operand; later input changes SHALL NOT affect the result.
- REQ-015 SHALL use rs2 as second operand for ALUreg and Iimm (sign-extended instr[31:20]) for ALUimm.
- REQ-016 SHALL decode funct3 instr[14:12] as 000 ADD/SUB, 001 SLL, 010 SLT (signed), 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- REQ-017 SHALL select SUB only when ALUreg and instr[30]=1, and SRA when instr[30]=1; shamt SHALL be operand2[4:0].
- REQ-018 SHALL compute all arithmetic modulo 2^32, discarding carries; SLT/SLTU SHALL yield 0 or 1.
- REQ-019 SHALL transition IDLE->DONE for non-shift ops or shamt=0, so done is high in the cycle after acceptance.
- REQ-020 SHALL transition IDLE->SHIFT for shifts with shamt>0, and each SHIFT cycle SHALL shift by SHIFT_STEP while remaining>=SHIFT_STEP, else by 1.
- REQ-021 SHALL leave SHIFT for DONE when remaining reaches 0, giving done at acceptance+1+floor(s/SHIFT_STEP)+(s mod SHIFT_STEP).
- REQ-022 SHALL transition DONE->IDLE unconditionally after one cycle.
- REQ-023 SHALL ignore start while ready=0, with no queuing.
- REQ-024 SHALL, for a non-ALU opcode, still pulse done with wb_data=0 and wb_en=0.
- REQ-025 SHALL drive wb_en=0 when wb_rd=0, while wb_data still carries the computed value.
- REQ-026 SHALL hold wb_data and wb_rd stable from DONE until the next acceptance.

Reset
- REQ-027 SHALL, while resetn=0 at a clock edge, force state IDLE, done=0, wb_en=0, wb_data=0, wb_rd=0 and the shift counter to 0.
- REQ-028 SHALL abort any SHIFT or DONE operation on reset with no done pulse, and SHALL drive ready=1 in the first cycle after that reset edge.

Configuration
- REQ-029 SHALL, with RV_ALU_BARREL_EN defined, perform all shifts in a single-cycle barrel shifter, never enter SHIFT, and give latency 1 for every op.
- REQ-030 SHALL, without RV_ALU_BARREL_EN, use the iterative shifter of REQ-020/021.

Structure
- REQ-031 SHALL take opcode constants, funct3 codes and the state enum from shared package rv32i_pkg.
- REQ-032 SHALL place shifting in sub-module rv32i_shifter, barrel or iterative per RV_ALU_BARREL_EN.

Verification
- REQ-033 SHALL verify ADDI x1,x1,1 with rs1=41: done one cycle after acceptance, wb_data=42, wb_en=1, wb_rd=1.
- REQ-034 SHALL verify with rs1=5, rs2=7: SUB gives 0xFFFFFFFE, SLT gives 1, SLTU gives 1, and SLTU with rs1=0xFFFFFFFF gives 0.
- REQ-035 SHALL verify SRA of rs1=0x80000000 with shamt 31 and SHIFT_STEP=4, macro off: done at acceptance+11, wb_data=0xFFFFFFFF; macro on: acceptance+1.
- REQ-036 SHALL verify ADD x0,x0,x0: done=1, wb_en=0; and a start pulsed during SHIFT is ignored, with exactly one done per accepted start.
- REQ-037 SHALL verify resetn=0 for one edge mid-SHIFT: no done pulse, all outputs 0, ready=1 the following cycle.
